// File: rtl/alu_result_stage_if.sv
// Handshake and payload bundle between the ALU, the result stage and writeback.
//   master : producer/consumer side (ALU drives the input half, writeback drives out_ready_i)
//   slave  : the result stage itself
interface alu_result_stage_if #(
    parameter int unsigned bits          = 32,
    parameter int unsigned reg_addr_bits = 4
);
    // ALU -> stage
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [bits-1:0]          result_i;
    logic                     flag_c_i;
    logic                     flag_n_i;
    logic                     flag_v_i;
    logic                     flag_z_i;
    logic                     set_flags_i;
    logic [reg_addr_bits-1:0] rd_i;
    logic                     we_i;
    // stage -> writeback
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [bits-1:0]          out_result_o;
    logic [reg_addr_bits-1:0] out_rd_o;
    logic                     out_we_o;

    modport master (
        output in_valid_i, result_i, flag_c_i, flag_n_i, flag_v_i, flag_z_i,
               set_flags_i, rd_i, we_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_result_o, out_rd_o, out_we_o
    );

    modport slave (
        input  in_valid_i, result_i, flag_c_i, flag_n_i, flag_v_i, flag_z_i,
               set_flags_i, rd_i, we_i, out_ready_i,
        output in_ready_o, out_valid_o, out_result_o, out_rd_o, out_we_o
    );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry valid/ready skid buffer (main = head, skid = overflow)
// carrying the ALU result, NZCV flags and destination info toward writeback.
// The architectural NZCV register is committed only when a flag-setting entry
// leaves the stage, so flushed entries never disturb the flags.
// Ports:
//   clk_i, rst_ni : rising-edge clock, asynchronous active-low reset
//   flush_i       : drop every entry that does not hand off this cycle
//   bus           : ALU input handshake + writeback output handshake
//   flags_o       : architectural {N,Z,C,V}
module alu_result_stage #(
    parameter int unsigned bits          = 32,
    parameter int unsigned reg_addr_bits = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    alu_result_stage_if.slave     bus,
    output logic [3:0]            flags_o
);

    typedef struct packed {
        logic [bits-1:0]          result;
        logic                     n;
        logic                     z;
        logic                     c;
        logic                     v;
        logic                     set_flags;
        logic [reg_addr_bits-1:0] rd;
        logic                     we;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   main_valid;
    logic   skid_valid;
    logic   in_fire;
    logic   out_fire;

    // Occupancy decoded from the state register
    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == FULL);

    // Flush blocks acceptance combinationally so nothing slips in behind a redirect
    assign bus.in_ready_o = !skid_valid && !flush_i;
    assign in_fire        = bus.in_valid_i && bus.in_ready_o;
    assign out_fire       = main_valid && bus.out_ready_i;

    assign in_entry = '{
        result:    bus.result_i,
        n:         bus.flag_n_i,
        z:         bus.flag_z_i,
        c:         bus.flag_c_i,
        v:         bus.flag_v_i,
        set_flags: bus.set_flags_i,
        rd:        bus.rd_i,
        we:        bus.we_i
    };

    // Head entry drives the writeback side directly from registers
    assign bus.out_valid_o  = main_valid;
    assign bus.out_result_o = main_q.result;
    assign bus.out_rd_o     = main_q.rd;
    assign bus.out_we_o     = main_q.we;

    // Buffer occupancy, entry movement and flag commit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            flags_o <= 4'b0000;
        end else begin
            // A head leaving the stage commits its flags even during a flush
            if (out_fire && main_q.set_flags) begin
                flags_o <= {main_q.n, main_q.z, main_q.c, main_q.v};
            end

            if (flush_i) begin
                state_q <= EMPTY;
            end else begin
                unique case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            main_q  <= in_entry;
                            state_q <= ONE;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            main_q  <= in_entry;
                        end else if (in_fire) begin
                            skid_q  <= in_entry;
                            state_q <= FULL;
                        end else if (out_fire) begin
                            state_q <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_fire) begin
                            main_q  <= skid_q;
                            state_q <= ONE;
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random
// traffic compared against a queue-based model of the stage.
module tb_alu_result_stage;

    localparam int unsigned BITS = 32;
    localparam int unsigned RAB  = 4;

    typedef struct {
        logic [BITS-1:0] result;
        logic            n;
        logic            z;
        logic            c;
        logic            v;
        logic            sf;
        logic [RAB-1:0]  rd;
        logic            we;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [3:0] flags;

    alu_result_stage_if #(.bits(BITS), .reg_addr_bits(RAB)) bus ();

    alu_result_stage #(.bits(BITS), .reg_addr_bits(RAB)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus),
        .flags_o (flags)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    logic [3:0] mflags = 4'b0000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the stage against the model, then advance both by one clock edge.
    task automatic step(input logic iv, input logic [BITS-1:0] res, input logic n,
                        input logic z, input logic c, input logic v, input logic sf,
                        input logic [RAB-1:0] rd, input logic we, input logic ordy,
                        input logic fl);
        ent_t e;
        bit   in_fire;
        bit   out_fire;
        @(negedge clk);
        bus.in_valid_i  = iv;
        bus.result_i    = res;
        bus.flag_n_i    = n;
        bus.flag_z_i    = z;
        bus.flag_c_i    = c;
        bus.flag_v_i    = v;
        bus.set_flags_i = sf;
        bus.rd_i        = rd;
        bus.we_i        = we;
        bus.out_ready_i = ordy;
        flush           = fl;
        #1;
        chk("in_ready", 64'(bus.in_ready_o), 64'((q.size() < 2) && !fl));
        chk("out_valid", 64'(bus.out_valid_o), 64'(q.size() > 0));
        chk("flags", 64'(flags), 64'(mflags));
        if (q.size() > 0) begin
            chk("out_result", 64'(bus.out_result_o), 64'(q[0].result));
            chk("out_rd", 64'(bus.out_rd_o), 64'(q[0].rd));
            chk("out_we", 64'(bus.out_we_o), 64'(q[0].we));
        end
        in_fire  = iv && (q.size() < 2) && !fl;
        out_fire = (q.size() > 0) && ordy;
        if (out_fire) begin
            if (q[0].sf) mflags = {q[0].n, q[0].z, q[0].c, q[0].v};
            void'(q.pop_front());
        end
        if (fl) begin
            q.delete();
        end else if (in_fire) begin
            e = '{result: res, n: n, z: z, c: c, v: v, sf: sf, rd: rd, we: we};
            q.push_back(e);
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, ordy, 1'b0);
    endtask

    task automatic push(input logic [BITS-1:0] res, input logic [3:0] nzcv, input logic sf,
                        input logic [RAB-1:0] rd, input logic ordy);
        step(1'b1, res, nzcv[3], nzcv[2], nzcv[1], nzcv[0], sf, rd, 1'b1, ordy, 1'b0);
    endtask

    initial begin
        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.result_i    = '0;
        bus.flag_n_i    = 1'b0;
        bus.flag_z_i    = 1'b0;
        bus.flag_c_i    = 1'b0;
        bus.flag_v_i    = 1'b0;
        bus.set_flags_i = 1'b0;
        bus.rd_i        = '0;
        bus.we_i        = 1'b0;
        bus.out_ready_i = 1'b0;
        #12;
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'(0));
        chk("rst_out_result", 64'(bus.out_result_o), 64'(0));
        chk("rst_out_rd", 64'(bus.out_rd_o), 64'(0));
        chk("rst_out_we", 64'(bus.out_we_o), 64'(0));
        chk("rst_flags", 64'(flags), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single transaction with flag update
        push(32'h0000_0005, 4'b0000, 1'b1, 4'd3, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Fill to FULL while stalled, then drain in order
        push(32'd1, 4'b0000, 1'b0, 4'd1, 1'b0);
        push(32'd2, 4'b0000, 1'b0, 4'd2, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Zero-bubble stream of 8
        for (int i = 0; i < 8; i++) push(32'h100 + 32'(i), 4'b0000, 1'b0, 4'(i), 1'b1);
        for (int i = 0; i < 2; i++) idle(1'b1);

        // Flag setter followed by non-setter: only the first updates NZCV
        push(32'h8000_0000, 4'b1000, 1'b1, 4'd5, 1'b0);
        push(32'h0000_0000, 4'b0100, 1'b0, 4'd6, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("flags_setter_only", 64'(flags), 64'(4'b1000));

        // Flush while FULL: head commits, skid dropped, input refused
        push(32'hA, 4'b0011, 1'b1, 4'd7, 1'b0);
        push(32'hB, 4'b1111, 1'b1, 4'd8, 1'b0);
        step(1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        chk("flush_flags", 64'(flags), 64'(4'b0011));
        idle(1'b1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

        // Async reset mid-stream with flags 0110
        idle(1'b1);
        idle(1'b1);
        push(32'h77, 4'b0110, 1'b1, 4'd1, 1'b1);
        idle(1'b1);
        push(32'h55, 4'b0000, 1'b0, 4'd2, 1'b0);
        push(32'h66, 4'b0000, 1'b0, 4'd3, 1'b0);
        @(negedge clk);
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        #1;
        chk("pre_rst_flags", 64'(flags), 64'(4'b0110));
        chk("pre_rst_valid", 64'(bus.out_valid_o), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_flags", 64'(flags), 64'(0));
        chk("async_rst_valid", 64'(bus.out_valid_o), 64'(0));
        q.delete();
        mflags = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        push(32'h99, 4'b1010, 1'b1, 4'd4, 1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
